ex_mem: RTL and testbench

EX_MEM -- requirements
Module: ex_mem

---
 rtl/ex_mem.sv | 120 ++++++++++++
 tb/tb_ex_mem.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// ex_mem: EX -> MEM pipeline register with multi-cycle MADD/MSUB feedback.
//
// Ports:
//   clk, rst         clock; async active-low reset (rst=0 clears everything)
//   stall[5:0]       bit3 = EX stalled, bit4 = MEM stalled; other bits unused
//   flush            exception flush, overrides every other action
//   ex_*             instruction result fields coming out of EX
//   hilo_i, cnt_i    MADD/MSUB partial product and step counter from EX
//   mem_*            registered copies presented to MEM
//   hilo_o, cnt_o    registered partial product / step counter fed back to EX
//
// Per-edge action, highest priority first:
//   flush   : everything cleared
//   bubble  : EX stalled, MEM running -> NOP into MEM, feedback loaded
//   capture : EX running -> ex_* into MEM, feedback cleared
//   hold    : EX and MEM stalled -> nothing changes
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic        mem_valid,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  logic        r_valid;
  logic [4:0]  r_wd;
  logic        r_wreg;
  logic [31:0] r_wdata;
  logic        r_whilo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_hilo;
  logic [1:0]  r_cnt;

  logic w_ex_stall;
  logic w_mem_stall;

  assign w_ex_stall  = stall[3];
  assign w_mem_stall = stall[4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_wd    <= 5'd0;
      r_wreg  <= 1'b0;
      r_wdata <= 32'd0;
      r_whilo <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_hilo  <= 64'd0;
      r_cnt   <= 2'd0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_wd    <= 5'd0;
      r_wreg  <= 1'b0;
      r_wdata <= 32'd0;
      r_whilo <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_hilo  <= 64'd0;
      r_cnt   <= 2'd0;
    end else if (w_ex_stall && !w_mem_stall) begin
      // Bubble: MEM sees a NOP while the partial product circulates back to EX.
      r_valid <= 1'b0;
      r_wd    <= 5'd0;
      r_wreg  <= 1'b0;
      r_wdata <= 32'd0;
      r_whilo <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_hilo  <= hilo_i;
      r_cnt   <= cnt_i;
    end else if (!w_ex_stall) begin
      // Capture (also taken for the illegal EX-running/MEM-stalled combination).
      // An invalid slot keeps its data fields but can never write state.
      r_valid <= ex_valid;
      r_wd    <= ex_wd;
      r_wreg  <= ex_wreg & ex_valid;
      r_wdata <= ex_wdata;
      r_whilo <= ex_whilo & ex_valid;
      r_hi    <= ex_hi;
      r_lo    <= ex_lo;
      r_hilo  <= 64'd0;
      r_cnt   <= 2'd0;
    end
    // else hold: every register keeps its value
  end

  assign mem_valid = r_valid;
  assign mem_wd    = r_wd;
  assign mem_wreg  = r_wreg;
  assign mem_wdata = r_wdata;
  assign mem_whilo = r_whilo;
  assign mem_hi    = r_hi;
  assign mem_lo    = r_lo;
  assign hilo_o    = r_hilo;
  assign cnt_o     = r_cnt;

  // EX running while MEM is stalled would drop an instruction upstream.
  a_illegal_stall: assert property (@(posedge clk) disable iff (!rst)
                                    !(!stall[3] && stall[4]));

endmodule

// File: tb/tb_ex_mem.sv
module tb_ex_mem;

  typedef struct packed {
    logic        flush;
    logic [5:0]  stall;
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic        ex_whilo = 1'b0;
  logic [31:0] ex_hi = '0;
  logic [31:0] ex_lo = '0;
  logic [63:0] hilo_i = '0;
  logic [1:0]  cnt_i = '0;
  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  out_t exp_q[$];
  int   id_q[$];
  int   checks = 0;
  int   failures = 0;
  event mon_ev;

  function automatic in_t mk_in(logic fl, logic [5:0] st, logic v, logic [4:0] wd,
                                logic wr, logic [31:0] wdat, logic wh,
                                logic [31:0] h, logic [31:0] l,
                                logic [63:0] hl, logic [1:0] c);
    in_t r;
    r = '{flush: fl, stall: st, valid: v, wd: wd, wreg: wr, wdata: wdat,
          whilo: wh, hi: h, lo: l, hilo: hl, cnt: c};
    return r;
  endfunction

  function automatic out_t mk_out(logic v, logic [4:0] wd, logic wr,
                                  logic [31:0] wdat, logic wh, logic [31:0] h,
                                  logic [31:0] l, logic [63:0] hl, logic [1:0] c);
    out_t r;
    r = '{valid: v, wd: wd, wreg: wr, wdata: wdat, whilo: wh, hi: h, lo: l,
          hilo: hl, cnt: c};
    return r;
  endfunction

  // Sampler: one sample per rising edge, 1 time unit after it.
  always @(posedge clk) begin
    #1;
    ->mon_ev;
  end

  // Monitor: pops the oldest expectation whenever a sample is taken.
  initial begin
    out_t e;
    out_t a;
    int   id;
    forever begin
      @(mon_ev);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        a  = '{valid: mem_valid, wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata,
               whilo: mem_whilo, hi: mem_hi, lo: mem_lo, hilo: hilo_o, cnt: cnt_o};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL vec%0d: got valid=%b wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h hilo=%h cnt=%0d, need valid=%b wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h hilo=%h cnt=%0d",
                   id, a.valid, a.wd, a.wreg, a.wdata, a.whilo, a.hi, a.lo, a.hilo, a.cnt,
                   e.valid, e.wd, e.wreg, e.wdata, e.whilo, e.hi, e.lo, e.hilo, e.cnt);
        end
      end
    end
  end

  task automatic apply(input in_t v);
    flush    = v.flush;
    stall    = v.stall;
    ex_valid = v.valid;
    ex_wd    = v.wd;
    ex_wreg  = v.wreg;
    ex_wdata = v.wdata;
    ex_whilo = v.whilo;
    ex_hi    = v.hi;
    ex_lo    = v.lo;
    hilo_i   = v.hilo;
    cnt_i    = v.cnt;
  endtask

  // Drive one vector for one rising edge and queue what must appear after it.
  task automatic vec(input int id, input in_t v, input out_t e);
    @(negedge clk);
    apply(v);
    exp_q.push_back(e);
    id_q.push_back(id);
    @(posedge clk);
  endtask

  localparam logic [5:0] S_RUN  = 6'b000000;
  localparam logic [5:0] S_BUB  = 6'b001000;
  localparam logic [5:0] S_HOLD = 6'b011000;

  initial begin
    out_t zero;
    zero = '0;

    // Reset state while rst is low, before any edge.
    #2;
    exp_q.push_back(zero); id_q.push_back(0);
    ->mon_ev;
    @(negedge clk);
    rst = 1'b1;

    // Capture
    vec(1, mk_in(0, S_RUN, 1, 5'd3, 1, 32'h1234_5678, 0, 32'h0, 32'h0, 64'h1111, 2'd2),
           mk_out(1, 5'd3, 1, 32'h1234_5678, 0, 32'h0, 32'h0, 64'h0, 2'd0));
    // MADD bubble, then a second bubble reloading the feedback
    vec(2, mk_in(0, S_BUB, 1, 5'd7, 1, 32'h0000_CAFE, 1, 32'h5, 32'h6,
                 64'hAAAA_0000_0000_5555, 2'd1),
           mk_out(0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'hAAAA_0000_0000_5555, 2'd1));
    vec(3, mk_in(0, S_BUB, 1, 5'd7, 1, 32'h0000_CAFE, 1, 32'h5, 32'h6,
                 64'h0123_4567_89AB_CDEF, 2'd2),
           mk_out(0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'h0123_4567_89AB_CDEF, 2'd2));
    // Capture ends the MADD and clears feedback
    vec(4, mk_in(0, S_RUN, 1, 5'd9, 1, 32'h55AA_55AA, 1, 32'h1111_2222, 32'h3333_4444,
                 64'hFFFF, 2'd3),
           mk_out(1, 5'd9, 1, 32'h55AA_55AA, 1, 32'h1111_2222, 32'h3333_4444, 64'h0, 2'd0));
    // Load DEADBEEF then hold 3 edges with changing inputs
    vec(5, mk_in(0, S_RUN, 1, 5'd4, 1, 32'hDEAD_BEEF, 0, 32'hA, 32'hB, 64'h0, 2'd0),
           mk_out(1, 5'd4, 1, 32'hDEAD_BEEF, 0, 32'hA, 32'hB, 64'h0, 2'd0));
    for (int i = 1; i <= 3; i++) begin
      vec(5 + i, mk_in(0, S_HOLD, 1, 5'(i + 10), 0, 32'(i), 1, 32'(i), 32'(i),
                       64'(i * 7), 2'(i)),
                 mk_out(1, 5'd4, 1, 32'hDEAD_BEEF, 0, 32'hA, 32'hB, 64'h0, 2'd0));
    end
    // Bubble then hold: feedback kept during hold
    vec(9,  mk_in(0, S_BUB, 0, 5'd1, 0, 32'h1, 0, 32'h0, 32'h0, 64'hFEDC_BA98_7654_3210, 2'd3),
            mk_out(0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'hFEDC_BA98_7654_3210, 2'd3));
    vec(10, mk_in(0, S_HOLD, 1, 5'd2, 1, 32'h2, 1, 32'h2, 32'h2, 64'h1234, 2'd1),
            mk_out(0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'hFEDC_BA98_7654_3210, 2'd3));
    // Full capture, then flush with hold stall
    vec(11, mk_in(0, S_RUN, 1, 5'd31, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'h12, 64'h9, 2'd1),
            mk_out(1, 5'd31, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'h12, 64'h0, 2'd0));
    vec(12, mk_in(0, S_BUB, 1, 5'd8, 1, 32'h8, 1, 32'h8, 32'h8, 64'h77, 2'd2),
            mk_out(0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'h77, 2'd2));
    vec(13, mk_in(0, S_RUN, 1, 5'd31, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'h12, 64'h9, 2'd1),
            mk_out(1, 5'd31, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'h12, 64'h0, 2'd0));
    vec(14, mk_in(1, S_HOLD, 1, 5'd5, 1, 32'h5, 1, 32'h5, 32'h5, 64'h55, 2'd1),
            zero);
    // Flush after a bubble also clears feedback
    vec(15, mk_in(0, S_BUB, 1, 5'd5, 1, 32'h5, 1, 32'h5, 32'h5, 64'h55, 2'd1),
            mk_out(0, 5'd0, 0, 32'h0, 0, 32'h0, 32'h0, 64'h55, 2'd1));
    vec(16, mk_in(1, S_BUB, 1, 5'd5, 1, 32'h5, 1, 32'h5, 32'h5, 64'h66, 2'd2),
            zero);
    // Invalid capture: write enables forced low, data passes
    vec(17, mk_in(0, S_RUN, 0, 5'd6, 1, 32'h0000_600D, 1, 32'h1, 32'h2, 64'h3, 2'd3),
            mk_out(0, 5'd6, 0, 32'h0000_600D, 0, 32'h1, 32'h2, 64'h0, 2'd0));
    // Async reset mid-cycle while mem_wdata=FFFFFFFF
    vec(18, mk_in(0, S_RUN, 1, 5'd2, 1, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 64'h0, 2'd0),
            mk_out(1, 5'd2, 1, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 64'h0, 2'd0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    exp_q.push_back(zero); id_q.push_back(19);
    ->mon_ev;
    @(negedge clk);
    rst = 1'b1;
    vec(20, mk_in(0, S_RUN, 1, 5'd5, 1, 32'h0BAD_F00D, 0, 32'h0, 32'h0, 64'h0, 2'd0),
            mk_out(1, 5'd5, 1, 32'h0BAD_F00D, 0, 32'h0, 32'h0, 64'h0, 2'd0));

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
